user_ram_arbiter: RTL and testbench
===================================

# user_ram_arbiter

Two-port round-robin arbiter and sequencer in front of the single-port `user_ram` word store. Port 0 serves the CPU bus bridge and port 1 serves the BRLWE accelerator. It serializes their read/write requests into the RAM's `wr_en_i`/`rd_en_i`/`addr_i`/`di_i` strobes. It also captures `do_o` in the single cycle it is valid, because the RAM drives `32'h16110400` when idle, and returns the read data to the requester that issued the read.

## Interface
Parameters:
- `ADDR_BIT`, default 8: word-address width; must match the attached `user_ram`.

Ports:
- `clk_i`  in  1  single clock for the whole block.
- `rst_i`  in  1  reset. One clock; reset is asynchronous and active-low.
- `p0_req_i`, `p1_req_i`  in  1  access request; held until the matching grant.
- `p0_we_i`, `p1_we_i`  in  1  1 = write, 0 = read.
- `p0_addr_i`, `p1_addr_i`  in  ADDR_BIT  word address.
- `p0_wdata_i`, `p1_wdata_i`  in  32  write data.
- `p0_gnt_o`, `p1_gnt_o`  out  1  one-cycle accept pulse; combinational from state and request.
- `p0_rvalid_o`, `p1_rvalid_o`  out  1  one-cycle read-data-valid pulse, registered.
- `rdata_o`  out  32  captured read data, shared by both ports; qualify with `pN_rvalid_o`.
- `busy_o`  out  1  high in any state other than IDLE.
- `ram_wr_en_o`, `ram_rd_en_o`  out  1  RAM strobes, registered.
- `ram_addr_o`  out  ADDR_BIT  RAM address, registered.
- `ram_di_o`  out  32  RAM write data, registered.
- `ram_do_i`  in  32  RAM read data.

## Operation
- FSM states:
  - IDLE: if any request is present, grant the winner and go to ACCESS; otherwise stay.
  - ACCESS: if write, go to IDLE; if read, go to CAPTURE.
  - CAPTURE: always go to IDLE.
- Arbitration happens in IDLE only:
  - A single requester wins.
  - If both request, the port not granted last wins (`last_q`).
  - `last_q` updates on every grant and resets to 1, so port 0 wins the first tie.
- On grant, register the winner's `we`/`addr`/`wdata` into the `ram_*` outputs and register the owner index `own_q`.
- ACCESS:
  - Exactly one of `ram_wr_en_o`/`ram_rd_en_o` is high, for exactly one cycle.
  - Both enables are low in every other state.
- CAPTURE: `rdata_o <= ram_do_i`; `p[own_q]_rvalid_o` pulses on the next cycle.
- `rdata_o` holds its value until the next capture.
- No request queueing; at most one request is in flight.
- A request arriving outside IDLE waits; its grant comes at the earliest IDLE cycle.
- A requester that drops `req` before its grant is never served.
- Reset, at any time including mid-read:
  - State goes to IDLE.
  - All outputs go to 0, `rdata_o` included.
  - `last_q` = 1; `own_q` = 0.
  - The in-flight read is discarded with no `rvalid`.
  - RAM contents are not touched; RAM reset is its own concern.

## Timing
- Grant at cycle T.
- Write: `ram_wr_en_o` high at T+1; IDLE at T+2; next grant possible at T+2. Throughput is one write per 2 cycles.
- Read: `ram_rd_en_o` high at T+1; RAM data valid at T+2 (CAPTURE); `pN_rvalid_o` and `rdata_o` valid at T+3. Next grant possible at T+3.
- `ram_do_i` is sampled only in CAPTURE; values at any other time are ignored.
- Both requests high in the same IDLE cycle: exactly one grant, never two.
- Continuous requests on both ports alternate grants 0,1,0,1.

## Structure
- Shared package `user_ram_pkg` holds:
  - the state enum (IDLE, ACCESS, CAPTURE);
  - port-index constants `PORT_CPU` = 0 and `PORT_ACC` = 1;
  - the idle-pattern constant `RAM_IDLE_WORD` = `32'h16110400`, for the bench.
- One sub-module: `rr_arb2`. Inputs are two requests and `last`; output is a one-hot grant. It is purely combinational; the `last_q` register stays in the top module.

## Test plan
- Reset then P0 writes `0x11` <- `0xDEADBEEF`: `p0_gnt_o` at T; `ram_wr_en_o`=1, `ram_addr_o`=`0x11`, `ram_di_o`=`0xDEADBEEF` at T+1; `busy_o` low at T+2.
- P1 reads `0x11` after the above: `ram_rd_en_o` at T+1; `p1_rvalid_o`=1 and `rdata_o`=`0xDEADBEEF` at T+3; `p0_rvalid_o` stays 0.
- Both ports request in the first cycle after reset, held high: grants in order P0, P1, P0, P1. Never two grants in one cycle.
- P0 raises `req` while a P1 read is in CAPTURE: P0 grant occurs at the first IDLE cycle, no earlier.
- `rst_i` asserted during ACCESS of a read: all outputs are 0 immediately (asynchronous); no `rvalid` after release; the first tie after release goes to P0.
- Idle RAM model driving `32'h16110400`, no requests: `rdata_o` stays 0 and no `rvalid` pulses.

Source files
------------

// File: rtl/user_ram_pkg.sv
// Shared types and constants for the user_ram arbiter and its bench.
package user_ram_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2
  } state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_ACC = 1'b1;

  localparam logic [31:0] RAM_IDLE_WORD = 32'h16110400;
endpackage

// File: rtl/user_ram_arbiter_rr_arb2.sv
// Two-way round-robin pick: on a tie the port that was not granted last wins.
module rr_arb2 (
  input  logic       req0_i,
  input  logic       req1_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);
  always_comb begin
    gnt_o[0] = req0_i & (~req1_i | last_i);
    gnt_o[1] = req1_i & (~req0_i | ~last_i);
  end
endmodule

// File: rtl/user_ram_arbiter.sv
// Serializes CPU-bridge and accelerator accesses onto the single-port user_ram
// and returns captured read data to whichever port issued the read.
module user_ram_arbiter
  import user_ram_pkg::*;
#(
  parameter int ADDR_BIT = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                p0_req_i,
  input  logic                p0_we_i,
  input  logic [ADDR_BIT-1:0] p0_addr_i,
  input  logic [31:0]         p0_wdata_i,
  input  logic                p1_req_i,
  input  logic                p1_we_i,
  input  logic [ADDR_BIT-1:0] p1_addr_i,
  input  logic [31:0]         p1_wdata_i,
  output logic                p0_gnt_o,
  output logic                p1_gnt_o,
  output logic                p0_rvalid_o,
  output logic                p1_rvalid_o,
  output logic [31:0]         rdata_o,
  output logic                busy_o,
  output logic                ram_wr_en_o,
  output logic                ram_rd_en_o,
  output logic [ADDR_BIT-1:0] ram_addr_o,
  output logic [31:0]         ram_di_o,
  input  logic [31:0]         ram_do_i
);
  state_e              state_q, state_d;
  logic                last_q, last_d;
  logic                own_q, own_d;
  logic                wr_en_q, wr_en_d;
  logic                rd_en_q, rd_en_d;
  logic [ADDR_BIT-1:0] addr_q, addr_d;
  logic [31:0]         di_q, di_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                p0_rvalid_q, p0_rvalid_d;
  logic                p1_rvalid_q, p1_rvalid_d;
  logic [1:0]          arb_gnt;
  logic [1:0]          gnt;

  rr_arb2 u_rr_arb2 (
    .req0_i (p0_req_i),
    .req1_i (p1_req_i),
    .last_i (last_q),
    .gnt_o  (arb_gnt)
  );

  // Grants only exist in IDLE; gating with the reset pin keeps them low while reset is held.
  assign gnt = (state_q == IDLE && rst_i) ? arb_gnt : 2'b00;

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    own_d       = own_q;
    wr_en_d     = 1'b0;
    rd_en_d     = 1'b0;
    addr_d      = addr_q;
    di_d        = di_q;
    rdata_d     = rdata_q;
    p0_rvalid_d = 1'b0;
    p1_rvalid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (|gnt) begin
          state_d = ACCESS;
          own_d   = gnt[1] ? PORT_ACC : PORT_CPU;
          last_d  = gnt[1] ? PORT_ACC : PORT_CPU;
          wr_en_d = gnt[1] ? p1_we_i : p0_we_i;
          rd_en_d = gnt[1] ? ~p1_we_i : ~p0_we_i;
          addr_d  = gnt[1] ? p1_addr_i : p0_addr_i;
          di_d    = gnt[1] ? p1_wdata_i : p0_wdata_i;
        end
      end
      ACCESS: state_d = wr_en_q ? IDLE : CAPTURE;
      CAPTURE: begin
        // ram_do_i is only meaningful here; elsewhere the RAM drives its idle word.
        rdata_d     = ram_do_i;
        p0_rvalid_d = (own_q == PORT_CPU);
        p1_rvalid_d = (own_q == PORT_ACC);
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      own_q       <= 1'b0;
      wr_en_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      addr_q      <= '0;
      di_q        <= '0;
      rdata_q     <= '0;
      p0_rvalid_q <= 1'b0;
      p1_rvalid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      own_q       <= own_d;
      wr_en_q     <= wr_en_d;
      rd_en_q     <= rd_en_d;
      addr_q      <= addr_d;
      di_q        <= di_d;
      rdata_q     <= rdata_d;
      p0_rvalid_q <= p0_rvalid_d;
      p1_rvalid_q <= p1_rvalid_d;
    end
  end

  assign p0_gnt_o    = gnt[0];
  assign p1_gnt_o    = gnt[1];
  assign p0_rvalid_o = p0_rvalid_q;
  assign p1_rvalid_o = p1_rvalid_q;
  assign rdata_o     = rdata_q;
  assign busy_o      = (state_q != IDLE);
  assign ram_wr_en_o = wr_en_q;
  assign ram_rd_en_o = rd_en_q;
  assign ram_addr_o  = addr_q;
  assign ram_di_o    = di_q;
endmodule

// File: tb/tb_user_ram_arbiter.sv
// Directed bench for user_ram_arbiter with a small synchronous user_ram model.
module tb_user_ram_arbiter;
  import user_ram_pkg::*;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [7:0]  p0_addr, p1_addr;
  logic [31:0] p0_wdata, p1_wdata;
  logic        p0_gnt, p1_gnt, p0_rv, p1_rv, busy, ram_wr_en, ram_rd_en;
  logic [31:0] rdata, ram_di;
  logic [7:0]  ram_addr;
  logic [31:0] ram_do;
  logic [31:0] mem [256];

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  user_ram_arbiter #(.ADDR_BIT(8)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .p0_req_i(p0_req), .p0_we_i(p0_we), .p0_addr_i(p0_addr), .p0_wdata_i(p0_wdata),
    .p1_req_i(p1_req), .p1_we_i(p1_we), .p1_addr_i(p1_addr), .p1_wdata_i(p1_wdata),
    .p0_gnt_o(p0_gnt), .p1_gnt_o(p1_gnt), .p0_rvalid_o(p0_rv), .p1_rvalid_o(p1_rv),
    .rdata_o(rdata), .busy_o(busy), .ram_wr_en_o(ram_wr_en), .ram_rd_en_o(ram_rd_en),
    .ram_addr_o(ram_addr), .ram_di_o(ram_di), .ram_do_i(ram_do)
  );

  // RAM model: registered read, idle word whenever no read was issued last cycle.
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    ram_do = RAM_IDLE_WORD;
  end
  always @(posedge clk) begin
    if (ram_wr_en) mem[ram_addr] <= ram_di;
    ram_do <= ram_rd_en ? mem[ram_addr] : RAM_IDLE_WORD;
  end

  typedef struct {
    logic r0, w0; logic [7:0] a0; logic [31:0] d0;
    logic r1, w1; logic [7:0] a1; logic [31:0] d1;
    logic [6:0]  exp_f;  // {gnt0,gnt1,wr_en,rd_en,busy,rvalid0,rvalid1}
    logic [31:0] exp_rdata;
    logic [7:0]  exp_addr;
    logic [31:0] exp_di;
  } vec_t;

  vec_t tbl [11];

  function automatic vec_t mk(logic r0, logic w0, logic [7:0] a0, logic [31:0] d0,
                              logic r1, logic w1, logic [7:0] a1, logic [31:0] d1,
                              logic [6:0] f, logic [31:0] rd, logic [7:0] ad, logic [31:0] di);
    vec_t v;
    v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.exp_f = f; v.exp_rdata = rd; v.exp_addr = ad; v.exp_di = di;
    return v;
  endfunction

  function automatic logic [6:0] flags();
    return {p0_gnt, p1_gnt, ram_wr_en, ram_rd_en, busy, p0_rv, p1_rv};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic drive(input logic r0, input logic w0, input logic [7:0] a0, input logic [31:0] d0,
                       input logic r1, input logic w1, input logic [7:0] a1, input logic [31:0] d1);
    p0_req = r0; p0_we = w0; p0_addr = a0; p0_wdata = d0;
    p1_req = r1; p1_we = w1; p1_addr = a1; p1_wdata = d1;
  endtask

  task automatic idle_in();
    drive(0, 0, 8'h0, 32'h0, 0, 0, 8'h0, 32'h0);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string nm);
    cyc();
    idle_in();
    rst_i = 1'b0;
    #1;
    chk({nm, "_rst_flags"}, 64'(flags()), 64'h0);
    chk({nm, "_rst_rdata"}, 64'(rdata), 64'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b1;
  endtask

  initial begin
    rst_i = 1'b1;
    idle_in();
    #1 rst_i = 1'b0;
    #1;
    chk("por_flags", 64'(flags()), 64'h0);
    chk("por_rdata", 64'(rdata), 64'h0);
    chk("por_addr",  64'(ram_addr), 64'h0);
    chk("por_di",    64'(ram_di), 64'h0);
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b1;

    // Idle cycles with the RAM showing its idle word, then P0 write and P1 read.
    for (int i = 0; i < 4; i++)
      tbl[i] = mk(0,0,8'h0,32'h0, 0,0,8'h0,32'h0, 7'b0000000, 32'h0, 8'h0, 32'h0);
    tbl[4]  = mk(1,1,8'h11,32'hDEADBEEF, 0,0,8'h0,32'h0,  7'b1000000, 32'h0, 8'h00, 32'h0);
    tbl[5]  = mk(0,0,8'h0,32'h0, 0,0,8'h0,32'h0,          7'b0010100, 32'h0, 8'h11, 32'hDEADBEEF);
    tbl[6]  = mk(0,0,8'h0,32'h0, 1,0,8'h11,32'h0,         7'b0100000, 32'h0, 8'h11, 32'hDEADBEEF);
    tbl[7]  = mk(0,0,8'h0,32'h0, 0,0,8'h0,32'h0,          7'b0001100, 32'h0, 8'h11, 32'h0);
    tbl[8]  = mk(0,0,8'h0,32'h0, 0,0,8'h0,32'h0,          7'b0000100, 32'h0, 8'h11, 32'h0);
    tbl[9]  = mk(0,0,8'h0,32'h0, 0,0,8'h0,32'h0,          7'b0000001, 32'hDEADBEEF, 8'h11, 32'h0);
    tbl[10] = mk(0,0,8'h0,32'h0, 0,0,8'h0,32'h0,          7'b0000000, 32'hDEADBEEF, 8'h11, 32'h0);

    for (int i = 0; i < 11; i++) begin
      cyc();
      drive(tbl[i].r0, tbl[i].w0, tbl[i].a0, tbl[i].d0, tbl[i].r1, tbl[i].w1, tbl[i].a1, tbl[i].d1);
      #1;
      chk($sformatf("tbl%0d_flags", i), 64'(flags()), 64'(tbl[i].exp_f));
      chk($sformatf("tbl%0d_rdata", i), 64'(rdata), 64'(tbl[i].exp_rdata));
      chk($sformatf("tbl%0d_addr", i),  64'(ram_addr), 64'(tbl[i].exp_addr));
      chk($sformatf("tbl%0d_di", i),    64'(ram_di), 64'(tbl[i].exp_di));
    end

    // Both ports request continuously: grants alternate P0, P1, P0, P1.
    do_reset("rr");
    for (int k = 0; k < 8; k++) begin
      cyc();
      drive(1, 1, 8'h20, 32'h12345678, 1, 1, 8'h21, 32'hCAFEF00D);
      #1;
      chk($sformatf("rr%0d_gnt", k), 64'({p0_gnt, p1_gnt}),
          64'({(k % 4 == 0), (k % 4 == 2)}));
    end
    cyc();
    idle_in();
    #1;
    chk("rr_done_flags", 64'(flags()), 64'h0);

    // P1 read; P0 request raised during CAPTURE is granted only at the next IDLE.
    cyc();
    drive(0, 0, 8'h0, 32'h0, 1, 0, 8'h21, 32'h0);
    #1;
    chk("cap_p1_gnt", 64'(flags()), 64'(7'b0100000));
    cyc();
    idle_in();
    #1;
    chk("cap_access", 64'(flags()), 64'(7'b0001100));
    cyc();
    drive(1, 1, 8'h30, 32'h00000055, 0, 0, 8'h0, 32'h0);
    #1;
    chk("cap_no_early_gnt", 64'(flags()), 64'(7'b0000100));
    cyc();
    #1;
    chk("cap_p0_gnt_rv1", 64'(flags()), 64'(7'b1000001));
    chk("cap_rdata", 64'(rdata), 64'hCAFEF00D);
    cyc();
    idle_in();
    #1;
    chk("cap_p0_write", 64'(flags()), 64'(7'b0010100));
    chk("cap_p0_addr", 64'(ram_addr), 64'h30);

    // Asynchronous reset in the ACCESS cycle of a read.
    cyc();
    drive(1, 0, 8'h20, 32'h0, 0, 0, 8'h0, 32'h0);
    #1;
    chk("ar_gnt", 64'(flags()), 64'(7'b1000000));
    cyc();
    idle_in();
    #1;
    chk("ar_access", 64'(flags()), 64'(7'b0001100));
    rst_i = 1'b0;
    #1;
    chk("ar_flags", 64'(flags()), 64'h0);
    chk("ar_rdata", 64'(rdata), 64'h0);
    chk("ar_addr",  64'(ram_addr), 64'h0);
    chk("ar_di",    64'(ram_di), 64'h0);
    drive(1, 1, 8'h40, 32'hA5A5A5A5, 1, 1, 8'h41, 32'h5A5A5A5A);
    #1;
    chk("ar_gnt_in_reset", 64'({p0_gnt, p1_gnt}), 64'h0);
    idle_in();
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      #1;
      chk($sformatf("ar_post%0d_flags", k), 64'(flags()), 64'h0);
      chk($sformatf("ar_post%0d_rdata", k), 64'(rdata), 64'h0);
    end
    cyc();
    drive(1, 1, 8'h40, 32'hA5A5A5A5, 1, 1, 8'h41, 32'h5A5A5A5A);
    #1;
    chk("ar_tie_p0", 64'(flags()), 64'(7'b1000000));
    cyc();
    idle_in();
    #1;
    chk("ar_tie_write", 64'(flags()), 64'(7'b0010100));
    chk("ar_tie_addr", 64'(ram_addr), 64'h40);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
